freq_div_bank: RTL and testbench
================================

FREQ_DIV_BANK -- requirements
Module: freq_div_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, meaning the number of independent divider channels (1..8).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, meaning the width of the divide value and of each channel counter.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 43, meaning the half-period in i_clk cycles loaded into every channel at reset (1..2^CNT_WIDTH-1).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, on ports i_clk and i_rst_n.
REQ-005 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 i_rst_n  input  1  synchronous active-low reset.
REQ-007 i_en  input  1  global count enable; low freezes all counters.
REQ-008 i_load  input  1  one-cycle request to write i_div into the channel selected by i_ch_sel.
REQ-009 i_ch_sel  input  max(1,$clog2(N_CH))  target channel for i_load.
REQ-010 i_div  input  CNT_WIDTH  requested half-period in i_clk cycles.
REQ-011 o_clk_div  output  N_CH  per-channel divided square wave, period 2*div cycles, 50% duty.
REQ-012 o_tick  output  N_CH  per-channel one-cycle pulse on every o_clk_div transition.
REQ-013 o_pending  output  N_CH  per-channel flag: a loaded value is waiting for its terminal count.
REQ-014 o_err  output  1  one-cycle pulse: i_load rejected (i_div==0, or i_ch_sel>=N_CH).

Function
REQ-015 Each channel SHALL hold an active divide register, a shadow register, a pending flag and a CNT_WIDTH counter.
REQ-016 With i_en high, the counter SHALL increment by one per cycle; terminal count is counter==active-1.
REQ-017 At terminal count, the counter SHALL return to 0, o_clk_div SHALL toggle and o_tick SHALL be 1; both are registered and change on the same edge.
REQ-018 o_tick SHALL be 0 in every cycle that is not a terminal-count cycle, and whenever i_en is low.
REQ-019 With i_en low, counters and o_clk_div SHALL hold; i_load SHALL still be accepted.
REQ-020 A valid i_load SHALL write i_div to the selected shadow register and set its o_pending on the next edge; the active value SHALL not change mid-period.
REQ-021 At a terminal count with pending set, active SHALL take the shadow value and pending SHALL clear on that same edge; the new half-period governs the very next half-cycle.
REQ-022 A valid i_load arriving in the same cycle as that channel's terminal count SHALL bypass the shadow: active takes i_div directly, pending stays or goes 0.
REQ-023 A second load before terminal count SHALL overwrite the shadow value; only the last one applies.
REQ-024 i_div==1 SHALL give a toggle every enabled cycle (period 2 cycles).
REQ-025 A rejected load SHALL pulse o_err for one cycle and SHALL leave every channel's registers unchanged.
REQ-026 Channels SHALL be fully independent; a load to one channel SHALL not affect another's phase.

Reset
REQ-027 On an edge with i_rst_n low: counters=0, active=shadow=DEFAULT_DIV, o_clk_div=0, o_tick=0, o_pending=0, o_err=0, regardless of i_en or i_load.
REQ-028 Reset asserted mid-period SHALL discard pending loads; the first toggle after release SHALL occur DEFAULT_DIV enabled cycles later.

Configuration
REQ-029 Macro FREQ_DIV_SYNC_EN: when defined, the block SHALL add input i_sync (1 bit); i_sync high for one cycle clears all counters and o_clk_div to 0 and applies pending shadows, aligning every channel's phase; i_sync has lower priority than reset and higher than i_load bypass.
REQ-030 Without FREQ_DIV_SYNC_EN, the port i_sync SHALL not exist and phase alignment is possible only via reset.

Verification
REQ-031 Reset, i_en=1 held -> o_clk_div[0] rises 43 cycles after reset release, period 86, o_tick pulses every 43 cycles.
REQ-032 Load ch1 div=5 at counter 10 -> o_pending[1]=1 next edge; at the next terminal count it clears; half-periods thereafter are 5 cycles.
REQ-033 Load div=0 or i_ch_sel=N_CH -> o_err one-cycle pulse; all o_pending stay 0; periods unchanged.
REQ-034 i_en low for 7 cycles mid-period -> that half-period lasts 43+7 cycles; o_tick 0 throughout the stall.
REQ-035 Load ch0 div=3 exactly on ch0 terminal count -> next half-period 3 cycles, o_pending[0] stays 0.
REQ-036 With FREQ_DIV_SYNC_EN, channels at divs 43 and 7 offset in phase, pulse i_sync -> both o_clk_div=0 next edge and both counters restart from 0 together.

Source files
------------

// File: rtl/freq_div_bank.sv
// freq_div_bank: bank of N_CH 50%-duty clock dividers with shadowed divide reload.
// Optional macro FREQ_DIV_SYNC_EN adds i_sync, which phase-aligns every channel.
module freq_div_bank #(
    parameter int N_CH        = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int DEFAULT_DIV = 43,
    localparam int SW = N_CH > 1 ? $clog2(N_CH) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_load,
`ifdef FREQ_DIV_SYNC_EN
    input  logic                 i_sync,
`endif
    input  logic [SW-1:0]        i_ch_sel,
    input  logic [CNT_WIDTH-1:0] i_div,
    output logic [N_CH-1:0]      o_clk_div,
    output logic [N_CH-1:0]      o_tick,
    output logic [N_CH-1:0]      o_pending,
    output logic                 o_err
);
    localparam logic [CNT_WIDTH-1:0] DEF = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic ok, sync;
    assign ok = i_load && i_div != '0 && int'(i_ch_sel) < N_CH;
`ifdef FREQ_DIV_SYNC_EN
    assign sync = i_sync;
`else
    assign sync = 1'b0;
`endif

    always_ff @(posedge i_clk)
        o_err <= i_rst_n && i_load && !ok;

    genvar c;
    generate
        for (c = 0; c < N_CH; c++) begin : g_ch
            logic [CNT_WIDTH-1:0] cnt, active, shadow;
            logic clk_q, tick_q, pend_q, hit, tc;
            assign hit = ok && int'(i_ch_sel) == c;
            assign tc  = i_en && cnt == active - ONE;
            assign o_clk_div[c] = clk_q;
            assign o_tick[c]    = tick_q;
            assign o_pending[c] = pend_q;
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    cnt    <= '0;
                    active <= DEF;
                    shadow <= DEF;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    pend_q <= 1'b0;
                end else if (sync) begin
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    active <= pend_q ? shadow : active;
                    pend_q <= hit;
                    shadow <= hit ? i_div : shadow;
                end else begin
                    tick_q <= tc;
                    if (tc) begin
                        // a load landing on terminal count goes straight to active
                        cnt    <= '0;
                        clk_q  <= ~clk_q;
                        active <= hit ? i_div : (pend_q ? shadow : active);
                        pend_q <= 1'b0;
                    end else begin
                        cnt    <= i_en ? cnt + ONE : cnt;
                        shadow <= hit ? i_div : shadow;
                        pend_q <= hit | pend_q;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_freq_div_bank.sv
// tb_freq_div_bank: directed and randomized checks of freq_div_bank against a countdown model.
module tb_freq_div_bank;
    localparam int N = 3;
    localparam int DEF = 43;

    logic clk = 0, rst_n, en, load, sync;
    logic [1:0] sel;
    logic [7:0] div;
    logic [N-1:0] o_clk_div, o_tick, o_pending;
    logic o_err;

    freq_div_bank #(.N_CH(N), .CNT_WIDTH(8), .DEFAULT_DIV(DEF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load),
`ifdef FREQ_DIV_SYNC_EN
        .i_sync(sync),
`endif
        .i_ch_sel(sel), .i_div(div),
        .o_clk_div(o_clk_div), .o_tick(o_tick), .o_pending(o_pending), .o_err(o_err));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit armed = 0;
    int m_rem[N], m_hp[N], m_sh[N];
    logic [N-1:0] m_clk, m_tick, m_pend;
    logic m_err;

    // model: each channel counts down the cycles left in its current half-period
    always @(posedge clk) begin
        bit ok, hit;
        if (!rst_n) begin
            armed = 1;
            m_clk = '0; m_tick = '0; m_pend = '0; m_err = 0;
            for (int c = 0; c < N; c++) begin m_rem[c] = DEF; m_hp[c] = DEF; m_sh[c] = DEF; end
        end else begin
            ok = load && div != 0 && sel < N;
            m_err = load && !ok;
            for (int c = 0; c < N; c++) begin
                hit = ok && sel == c;
                m_tick[c] = 0;
                if (sync) begin
                    if (m_pend[c]) m_hp[c] = m_sh[c];
                    m_rem[c] = m_hp[c];
                    m_clk[c] = 0;
                    m_pend[c] = 0;
                    if (hit) begin m_sh[c] = div; m_pend[c] = 1; end
                end else if (en && m_rem[c] == 1) begin
                    m_clk[c] = ~m_clk[c];
                    m_tick[c] = 1;
                    if (hit) m_hp[c] = div;
                    else if (m_pend[c]) m_hp[c] = m_sh[c];
                    m_pend[c] = 0;
                    m_rem[c] = m_hp[c];
                end else begin
                    if (en) m_rem[c]--;
                    if (hit) begin m_sh[c] = div; m_pend[c] = 1; end
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (armed) begin
        chk("clk_div", int'(o_clk_div), int'(m_clk));
        chk("tick", int'(o_tick), int'(m_tick));
        chk("pending", int'(o_pending), int'(m_pend));
        chk("err", int'(o_err), int'(m_err));
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_tick(int c, output int n);
        n = 0;
        do begin step(); n++; end while (!o_tick[c] && n < 600);
    endtask

    initial begin
        int n, m;
        rst_n = 0; en = 0; load = 0; sync = 0; sel = 0; div = 0;
        repeat (3) step();
        chk("rst_clk_div", int'(o_clk_div), 0);
        chk("rst_tick", int'(o_tick), 0);
        chk("rst_pending", int'(o_pending), 0);
        chk("rst_err", int'(o_err), 0);
        rst_n = 1; en = 1;
        n = 0;
        do begin step(); n++; end while (!o_clk_div[0] && n < 300);
        chk("first_rise", n, 43);
        chk("tick_at_rise", int'(o_tick[0]), 1);
        n = 0;
        do begin step(); n++; end while (o_clk_div[0] && n < 300);
        chk("first_fall", n, 43);
        repeat (10) step();
        load = 1; sel = 1; div = 5;
        step();
        load = 0;
        chk("pend1_set", int'(o_pending[1]), 1);
        wait_tick(1, n);
        chk("pend1_clear", int'(o_pending[1]), 0);
        wait_tick(1, n);
        chk("ch1_half5", n, 5);
        load = 1; sel = 0; div = 0;
        step();
        load = 0;
        chk("err_div0", int'(o_err), 1);
        chk("err_div0_pend", int'(o_pending), 0);
        step();
        chk("err_one_cycle", int'(o_err), 0);
        load = 1; sel = 3; div = 5;
        step();
        load = 0;
        chk("err_sel", int'(o_err), 1);
        chk("err_sel_pend", int'(o_pending), 0);
        wait_tick(0, n);
        n = 0;
        repeat (10) begin step(); n++; end
        en = 0;
        repeat (7) begin step(); n++; chk("stall_tick", int'(o_tick[0]), 0); end
        en = 1;
        wait_tick(0, m);
        chk("stall_half", n + m, 50);
        n = 0;
        while (m_rem[0] != 1 && n < 200) begin step(); n++; end
        load = 1; sel = 0; div = 3;
        step();
        load = 0;
        chk("bypass_tick", int'(o_tick[0]), 1);
        chk("bypass_pend", int'(o_pending[0]), 0);
        wait_tick(0, n);
        chk("bypass_half3", n, 3);
        for (int i = 0; i < 4000; i++) begin
            rst_n = $urandom_range(0, 499) != 0;
            en = $urandom_range(0, 9) != 0;
            load = $urandom_range(0, 7) == 0;
            sel = 2'($urandom_range(0, 3));
            div = $urandom_range(0, 4) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
`ifdef FREQ_DIV_SYNC_EN
            sync = $urandom_range(0, 99) == 0;
`endif
            step();
        end
        rst_n = 1; load = 0; en = 1;
`ifdef FREQ_DIV_SYNC_EN
        repeat (20) step();
        sync = 1;
        step();
        sync = 0;
        chk("sync_clk_div", int'(o_clk_div), 0);
`endif
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
